// File: rtl/save.sv
// save: decodes a save instruction, reads a contiguous range of the result
// buffer selected by the group field and streams it as AXI4-Stream beats to
// the DRAM write master, then waits for the master's completion before
// pulsing ap_done.
module save #(
    parameter int SAVE_INST_LENGTH    = 96,
    parameter int C_M_AXI_ADDR_WIDTH  = 64,
    parameter int C_M_AXI_DATA_WIDTH  = 512,
    parameter int C_XFER_SIZE_WIDTH   = 32,
    parameter int C_BUFFER_ADDR_WIDTH = 11
) (
    input  logic                           kernel_clk,
    input  logic                           kernel_rst,
    input  logic                           ap_start,
    output logic                           ap_done,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]  ctrl_addr_offset,
    input  logic [SAVE_INST_LENGTH-1:0]    ctrl_instruction,
    output logic                           save_read_buffer_0_valid,
    output logic [C_BUFFER_ADDR_WIDTH-1:0] save_read_buffer_0_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]  save_read_buffer_0_data,
    output logic                           save_read_buffer_1_valid,
    output logic [C_BUFFER_ADDR_WIDTH-1:0] save_read_buffer_1_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]  save_read_buffer_1_data,
    output logic                           wr_ctrl_start,
    input  logic                           wr_ctrl_done,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]  wr_ctrl_addr_offset,
    output logic [C_XFER_SIZE_WIDTH-1:0]   wr_ctrl_xfer_size_in_bytes,
    output logic                           data_tvalid,
    input  logic                           data_tready,
    output logic                           data_tlast,
    output logic [C_M_AXI_DATA_WIDTH-1:0]  data_tdata
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_DECODE    = 3'd1;
    localparam logic [2:0] S_START     = 3'd2;
    localparam logic [2:0] S_STREAM    = 3'd3;
    localparam logic [2:0] S_WAIT_DONE = 3'd4;

    logic [2:0]                     state;
    logic [5:0]                     group_q;
    logic [C_BUFFER_ADDR_WIDTH-1:0] buf_start_q;
    logic [15:0]                    buf_len_q;
    logic [15:0]                    dram_start_q;
    logic [15:0]                    dram_bytes_q;
    logic [C_M_AXI_ADDR_WIDTH-1:0]  base_q;
    logic [15:0]                    rd_cnt;
    logic [15:0]                    out_cnt;
    logic                           done_seen;

    // Skid FIFO plus the one read that may be in flight from the buffer.
    logic [C_M_AXI_DATA_WIDTH-1:0]  fifo_mem [2];
    logic                           wr_ptr;
    logic                           rd_ptr;
    logic [1:0]                     fifo_count;
    logic                           rd_pending;

    logic                           fifo_empty;
    logic                           pop;
    logic                           fifo_push;
    logic                           fifo_pop;
    logic                           rd_issue;
    logic [2:0]                     occupancy;
    logic [C_BUFFER_ADDR_WIDTH-1:0] rd_addr;
    logic [C_M_AXI_DATA_WIDTH-1:0]  rd_data;
    logic                           inst_valid;

    assign inst_valid = (buf_len_q != 16'd0) && ((group_q == 6'b000001) || (group_q == 6'b000010));
    assign rd_data    = group_q[0] ? save_read_buffer_0_data : save_read_buffer_1_data;
    assign fifo_empty = (fifo_count == 2'd0);

    // A word coming back from the buffer is presented directly when the FIFO
    // is empty, so the first beat is visible the cycle after its read.
    assign data_tvalid = !fifo_empty || rd_pending;
    assign data_tdata  = !fifo_empty ? fifo_mem[rd_ptr] :
                         (rd_pending ? rd_data : '0);
    assign data_tlast  = data_tvalid && (out_cnt == buf_len_q - 16'd1);

    assign pop       = data_tvalid && data_tready;
    assign fifo_pop  = pop && !fifo_empty;
    assign fifo_push = rd_pending && !(fifo_empty && data_tready);

    // Reads in flight count against FIFO space so a returning word always
    // has a slot, whatever the stream does in the meantime.
    assign occupancy = {1'b0, fifo_count} + {2'b00, rd_pending};
    assign rd_issue  = (state == S_STREAM) && (rd_cnt < buf_len_q) &&
                       ((occupancy - {2'b00, pop}) < 3'd2);
    assign rd_addr   = buf_start_q + rd_cnt[C_BUFFER_ADDR_WIDTH-1:0];

    assign save_read_buffer_0_valid = rd_issue && group_q[0];
    assign save_read_buffer_1_valid = rd_issue && group_q[1];
    assign save_read_buffer_0_addr  = save_read_buffer_0_valid ? rd_addr : '0;
    assign save_read_buffer_1_addr  = save_read_buffer_1_valid ? rd_addr : '0;
    assign wr_ctrl_start            = (state == S_START);

    // Instruction sequencing: latch, decode, kick the master, stream, wait.
    always_ff @(posedge kernel_clk) begin
        if (kernel_rst) begin
            state                      <= S_IDLE;
            ap_done                    <= 1'b1;
            group_q                    <= '0;
            buf_start_q                <= '0;
            buf_len_q                  <= '0;
            dram_start_q               <= '0;
            dram_bytes_q               <= '0;
            base_q                     <= '0;
            rd_cnt                     <= '0;
            out_cnt                    <= '0;
            done_seen                  <= 1'b0;
            wr_ctrl_addr_offset        <= '0;
            wr_ctrl_xfer_size_in_bytes <= '0;
        end else begin
            ap_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    done_seen <= 1'b0;
                    if (ap_start) begin
                        group_q      <= ctrl_instruction[5:0];
                        buf_start_q  <= ctrl_instruction[32 +: C_BUFFER_ADDR_WIDTH];
                        buf_len_q    <= ctrl_instruction[63:48];
                        dram_start_q <= ctrl_instruction[79:64];
                        dram_bytes_q <= ctrl_instruction[95:80];
                        base_q       <= ctrl_addr_offset;
                        state        <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    wr_ctrl_addr_offset <= base_q +
                        {{(C_M_AXI_ADDR_WIDTH-16){1'b0}}, dram_start_q};
                    wr_ctrl_xfer_size_in_bytes <=
                        {{(C_XFER_SIZE_WIDTH-16){1'b0}}, dram_bytes_q};
                    rd_cnt  <= '0;
                    out_cnt <= '0;
                    if (inst_valid) begin
                        state <= S_START;
                    end else begin
                        ap_done <= 1'b1;
                        state   <= S_IDLE;
                    end
                end
                S_START: begin
                    if (wr_ctrl_done) done_seen <= 1'b1;
                    state <= S_STREAM;
                end
                S_STREAM: begin
                    if (wr_ctrl_done) done_seen <= 1'b1;
                    if (rd_issue)     rd_cnt    <= rd_cnt + 16'd1;
                    if (pop)          out_cnt   <= out_cnt + 16'd1;
                    if (pop && data_tlast) state <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (wr_ctrl_done || done_seen) begin
                        ap_done <= 1'b1;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // FIFO bookkeeping and read-return tracking.
    always_ff @(posedge kernel_clk) begin
        if (kernel_rst) begin
            rd_pending <= 1'b0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= 2'd0;
        end else begin
            rd_pending <= rd_issue;
            if (fifo_push) wr_ptr <= ~wr_ptr;
            if (fifo_pop)  rd_ptr <= ~rd_ptr;
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // FIFO storage.
    // NOTE: data storage has no reset; fifo_count alone says which slots are
    // meaningful, and leaving wide data unreset keeps it plain flops/LUTRAM.
    always_ff @(posedge kernel_clk) begin
        if (fifo_push) fifo_mem[wr_ptr] <= rd_data;
    end

endmodule

// File: tb/tb_save.sv
// Self-checking bench for save: a table of instructions with hand-computed
// expectations, plus directed sequences for back-to-back starts, ignored
// ap_start during streaming and reset in the middle of a transfer.
module tb_save;

    logic         kernel_clk;
    logic         kernel_rst;
    logic         ap_start;
    logic         ap_done;
    logic [63:0]  ctrl_addr_offset;
    logic [95:0]  ctrl_instruction;
    logic         b0_valid;
    logic [10:0]  b0_addr;
    logic [511:0] b0_data;
    logic         b1_valid;
    logic [10:0]  b1_addr;
    logic [511:0] b1_data;
    logic         wr_ctrl_start;
    logic         wr_ctrl_done;
    logic [63:0]  wr_ctrl_addr_offset;
    logic [31:0]  wr_ctrl_xfer_size_in_bytes;
    logic         data_tvalid;
    logic         data_tready;
    logic         data_tlast;
    logic [511:0] data_tdata;

    int n_vec = 0;
    int n_bad = 0;

    save dut (
        .kernel_clk                 (kernel_clk),
        .kernel_rst                 (kernel_rst),
        .ap_start                   (ap_start),
        .ap_done                    (ap_done),
        .ctrl_addr_offset           (ctrl_addr_offset),
        .ctrl_instruction           (ctrl_instruction),
        .save_read_buffer_0_valid   (b0_valid),
        .save_read_buffer_0_addr    (b0_addr),
        .save_read_buffer_0_data    (b0_data),
        .save_read_buffer_1_valid   (b1_valid),
        .save_read_buffer_1_addr    (b1_addr),
        .save_read_buffer_1_data    (b1_data),
        .wr_ctrl_start              (wr_ctrl_start),
        .wr_ctrl_done               (wr_ctrl_done),
        .wr_ctrl_addr_offset        (wr_ctrl_addr_offset),
        .wr_ctrl_xfer_size_in_bytes (wr_ctrl_xfer_size_in_bytes),
        .data_tvalid                (data_tvalid),
        .data_tready                (data_tready),
        .data_tlast                 (data_tlast),
        .data_tdata                 (data_tdata)
    );

    initial begin
        kernel_clk = 1'b0;
        forever #5 kernel_clk = ~kernel_clk;
    end

    // Word stored at buffer b, address a: recognisable in every 32-bit lane.
    function automatic logic [511:0] pat(input bit b, input logic [10:0] a);
        logic [511:0] r;
        for (int i = 0; i < 16; i++)
            r[i*32 +: 32] = {(b ? 8'hB1 : 8'hB0), 8'(i), 5'b00000, a};
        return r;
    endfunction

    // Buffers return data one cycle after the strobe, garbage otherwise.
    always @(posedge kernel_clk) begin
        b0_data <= b0_valid ? pat(1'b0, b0_addr) : {16{32'hDEAD_BEEF}};
        b1_data <= b1_valid ? pat(1'b1, b1_addr) : {16{32'hFEED_F00D}};
    end

    typedef struct {
        logic [5:0]  group;
        logic [15:0] bs;
        logic [15:0] len;
        logic [15:0] ds;
        logic [15:0] db;
        logic [63:0] offset;
        int          mode;      // 0: tready=1, 1: 1,0,0,1,0,1 pattern, 2: low until cycle 10
        logic [63:0] exp_addr;
        int          exp_last;  // cycle of last beat, 0 when not hand-derived
        bit          early;     // wr_ctrl_done pulsed during STREAM
    } vec_t;

    vec_t vecs [8];

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_wide(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [95:0] mk_inst(input vec_t v);
        logic [95:0] r;
        r        = '0;
        r[5:0]   = v.group;
        r[47:32] = v.bs;
        r[63:48] = v.len;
        r[79:64] = v.ds;
        r[95:80] = v.db;
        return r;
    endfunction

    function automatic logic tready_of(input int mode, input int cyc);
        case (mode)
            1: case (cyc % 6)
                   0, 3, 5: return 1'b1;
                   default: return 1'b0;
               endcase
            2: return cyc >= 10;
            default: return 1'b1;
        endcase
    endfunction

    task automatic check_zero_outputs(input string tag);
        check_int({tag, "_tvalid"}, int'(data_tvalid), 0);
        check_int({tag, "_tlast"}, int'(data_tlast), 0);
        check_wide({tag, "_tdata"}, data_tdata, '0);
        check_int({tag, "_rd_valid"}, int'({b1_valid, b0_valid}), 0);
        check_int({tag, "_rd_addr"}, int'({b1_addr, b0_addr}), 0);
        check_int({tag, "_wr_start"}, int'(wr_ctrl_start), 0);
        check_wide({tag, "_wr_addr"}, 512'(wr_ctrl_addr_offset), '0);
        check_int({tag, "_wr_size"}, int'(wr_ctrl_xfer_size_in_bytes), 0);
    endtask

    // Runs one instruction. Cycle 0 is the ap_start cycle; skip_start means
    // ap_start was already driven in cycle 0 by the previous run's chain.
    task automatic run_vec(input vec_t v, input bit skip_start, input bit poke,
                           input bit chain, input vec_t nxt);
        int cyc, reads, beats, starts, wrong, first_valid, last_cyc;
        int done_at, done_cyc, start_cyc, max_occ;
        bit sel1, valid_inst;
        logic [63:0] seen_addr;
        logic [31:0] seen_size;
        logic [10:0] exp_ra;
        valid_inst = (v.len != 0) && (v.group == 6'd1 || v.group == 6'd2);
        sel1 = (v.group == 6'd2);
        reads = 0; beats = 0; starts = 0; wrong = 0; max_occ = 0;
        first_valid = -1; last_cyc = -1; done_cyc = -1; start_cyc = -1;
        seen_addr = '0; seen_size = '0;
        done_at = v.early ? 4 : -1;
        cyc = skip_start ? 1 : 0;
        while (done_cyc < 0 && cyc < 200) begin
            @(negedge kernel_clk);
            ap_start         = (cyc == 0) || (poke && cyc >= 3 && cyc <= 5);
            ctrl_instruction = mk_inst(v);
            ctrl_addr_offset = v.offset;
            data_tready      = tready_of(v.mode, cyc);
            wr_ctrl_done     = (cyc == done_at);
            #1;
            exp_ra = 11'(int'(v.bs) + reads);
            if (b0_valid) begin
                if (sel1) wrong++;
                else check_int("rd_addr_b0", int'(b0_addr), int'(exp_ra));
            end
            if (b1_valid) begin
                if (!sel1) wrong++;
                else check_int("rd_addr_b1", int'(b1_addr), int'(exp_ra));
            end
            if (b0_valid || b1_valid) reads++;
            if (wr_ctrl_start) begin
                starts++;
                start_cyc = cyc;
                seen_addr = wr_ctrl_addr_offset;
                seen_size = wr_ctrl_xfer_size_in_bytes;
            end
            if (data_tvalid) begin
                if (first_valid < 0) first_valid = cyc;
                check_wide("tdata", data_tdata, pat(sel1, 11'(int'(v.bs) + beats)));
                check_int("tlast", int'(data_tlast), int'(beats == int'(v.len) - 1));
                if (data_tready) begin
                    beats++;
                    if (beats == int'(v.len)) begin
                        last_cyc = cyc;
                        if (!v.early) done_at = cyc + 3;
                    end
                end
            end
            if (reads - beats > max_occ) max_occ = reads - beats;
            if (ap_done) begin
                done_cyc = cyc;
                if (chain) begin
                    ap_start         = 1'b1;
                    ctrl_instruction = mk_inst(nxt);
                    ctrl_addr_offset = nxt.offset;
                end
            end
            cyc++;
        end
        check_int("done_seen_in_budget", int'(done_cyc >= 0), 1);
        check_int("reads", reads, valid_inst ? int'(v.len) : 0);
        check_int("wrong_buffer_strobes", wrong, 0);
        check_int("starts", starts, valid_inst ? 1 : 0);
        check_int("beats", beats, valid_inst ? int'(v.len) : 0);
        if (valid_inst) begin
            check_int("start_cycle", start_cyc, 2);
            check_wide("wr_addr", 512'(seen_addr), 512'(v.exp_addr));
            check_int("wr_size", int'(seen_size), int'(v.db));
            check_int("first_tvalid_cycle", first_valid, 4);
            if (v.exp_last != 0) check_int("last_beat_cycle", last_cyc, v.exp_last);
            check_int("done_cycle", done_cyc, last_cyc + (v.early ? 2 : 4));
            check_int("occupancy_le_2", int'(max_occ <= 2), 1);
        end else begin
            check_int("done_cycle", done_cyc, 2);
        end
        if (!chain) begin
            @(negedge kernel_clk);
            ap_start     = 1'b0;
            wr_ctrl_done = 1'b0;
            #1;
            check_int("done_pulse_width", int'(ap_done), 0);
        end
    endtask

    initial begin
        int beats;
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int beats;
        //        group      bs        len    ds        db        offset                 mode exp_addr               last early
        vecs[0] = '{6'd1, 16'd16,   16'd4, 16'h0040, 16'h0100, 64'h1000,              0, 64'h1040,              7,  1'b0};
        vecs[1] = '{6'd1, 16'd16,   16'd4, 16'h0040, 16'h0100, 64'h1000,              1, 64'h1040,              0,  1'b0};
        vecs[2] = '{6'd2, 16'd2046, 16'd4, 16'h0080, 16'h0100, 64'h0000_2000_0000_0000, 0, 64'h0000_2000_0000_0080, 7, 1'b0};
        vecs[3] = '{6'd1, 16'd16,   16'd0, 16'h0040, 16'h0100, 64'h1000,              0, 64'h1040,              0,  1'b0};
        vecs[4] = '{6'd4, 16'd16,   16'd4, 16'h0040, 16'h0100, 64'h1000,              0, 64'h1040,              0,  1'b0};
        vecs[5] = '{6'd1, 16'd100,  16'd1, 16'hFFFF, 16'hFFFF, 64'hFFFF_FFFF_FFFF_0000, 0, 64'hFFFF_FFFF_FFFF_FFFF, 4, 1'b1};
        vecs[6] = '{6'd2, 16'd5,    16'd6, 16'h0010, 16'h0180, 64'h3000,              2, 64'h3010,              15, 1'b0};
        vecs[7] = '{6'd3, 16'd16,   16'd4, 16'h0040, 16'h0100, 64'h1000,              0, 64'h1040,              0,  1'b0};

        kernel_rst       = 1'b1;
        ap_start         = 1'b0;
        ctrl_addr_offset = '0;
        ctrl_instruction = '0;
        wr_ctrl_done     = 1'b0;
        data_tready      = 1'b0;

        // Reset state.
        @(negedge kernel_clk);
        #1;
        check_int("reset_ap_done", int'(ap_done), 1);
        check_zero_outputs("reset");
        @(negedge kernel_clk);
        kernel_rst = 1'b0;
        @(negedge kernel_clk);
        #1;
        check_int("reset_ap_done_falls", int'(ap_done), 0);

        // Table-driven instructions.
        for (int i = 0; i < 8; i++) run_vec(vecs[i], 1'b0, 1'b0, 1'b0, vecs[i]);

        // ap_start held during STREAM is ignored; next instruction is started
        // in the very cycle ap_done is high.
        run_vec(vecs[0], 1'b0, 1'b1, 1'b1, vecs[2]);
        run_vec(vecs[2], 1'b1, 1'b0, 1'b0, vecs[2]);

        // Reset after two beats have been accepted.
        @(negedge kernel_clk);
        ap_start         = 1'b1;
        ctrl_instruction = mk_inst(vecs[0]);
        ctrl_addr_offset = vecs[0].offset;
        data_tready      = 1'b1;
        beats = 0;
        for (int c = 1; c < 50 && beats < 2; c++) begin
            @(negedge kernel_clk);
            ap_start = 1'b0;
            #1;
            if (data_tvalid && data_tready) beats++;
        end
        check_int("beats_before_reset", beats, 2);
        @(negedge kernel_clk);
        kernel_rst = 1'b1;
        @(negedge kernel_clk);
        kernel_rst = 1'b0;
        #1;
        check_int("midrst_ap_done", int'(ap_done), 1);
        check_zero_outputs("midrst");
        @(negedge kernel_clk);
        #1;
        check_int("midrst_ap_done_falls", int'(ap_done), 0);
        check_int("midrst_no_tvalid", int'(data_tvalid), 0);
        run_vec(vecs[6], 1'b0, 1'b0, 1'b0, vecs[6]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/save.md
Name: save

Overview:
- DRAM-ward counterpart of the load engine: decodes a 96-bit save instruction, reads a contiguous range of an on-chip result buffer, and streams the words as AXI4-Stream beats into an external AXI write master.
- Drives the write master's start/address/size control and waits for its completion before signalling ap_done to the ctrl module.
- Single clock domain (kernel_clk). It contains a 2-entry skid FIFO so that the 1-cycle buffer read latency tolerates stream backpressure.

Parameters:
- SAVE_INST_LENGTH, 96: instruction width.
- C_M_AXI_ADDR_WIDTH, 64: DRAM address width.
- C_M_AXI_DATA_WIDTH, 512: buffer word and stream beat width.
- C_XFER_SIZE_WIDTH, 32: transfer size width.
- C_BUFFER_ADDR_WIDTH, 11: buffer address width.

Ports:
- kernel_clk  in  1  clock.
- kernel_rst  in  1  synchronous active-high reset.
- ap_start  in  1  instruction valid; sampled only in IDLE.
- ap_done  out  1  completion pulse.
- ctrl_addr_offset  in  C_M_AXI_ADDR_WIDTH  DRAM base.
- ctrl_instruction  in  SAVE_INST_LENGTH  group[5:0], buf_start[47:32], buf_len[63:48], dram_start[79:64], dram_bytes[95:80].
- save_read_buffer_0_valid  out  1  read strobe, buffer 2_A.
- save_read_buffer_0_addr  out  C_BUFFER_ADDR_WIDTH  read address, buffer 2_A.
- save_read_buffer_0_data  in  C_M_AXI_DATA_WIDTH  read data, buffer 2_A; valid 1 cycle after the strobe.
- save_read_buffer_1_valid  out  1  read strobe, buffer 2_B.
- save_read_buffer_1_addr  out  C_BUFFER_ADDR_WIDTH  read address, buffer 2_B.
- save_read_buffer_1_data  in  C_M_AXI_DATA_WIDTH  read data, buffer 2_B; valid 1 cycle after the strobe.
- wr_ctrl_start  out  1  write master start pulse.
- wr_ctrl_done  in  1  write master completion pulse.
- wr_ctrl_addr_offset  out  C_M_AXI_ADDR_WIDTH  DRAM byte address.
- wr_ctrl_xfer_size_in_bytes  out  C_XFER_SIZE_WIDTH  byte count.
- data_tvalid  out  1  stream valid.
- data_tready  in  1  stream ready.
- data_tlast  out  1  last beat of the instruction.
- data_tdata  out  C_M_AXI_DATA_WIDTH  stream data.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - ap_done=1; it falls to 0 on the first cycle after reset.
  - All other outputs are 0.
  - FIFO empty, counters 0, state IDLE.
  - Reset mid-operation aborts the instruction immediately. No ap_done pulse is produced beyond the reset-value one.
- State machine: IDLE -> DECODE -> START -> STREAM -> WAIT_DONE -> IDLE.
- IDLE:
  - ap_start=1 latches instruction fields and ctrl_addr_offset, then goes to DECODE.
  - ap_start is ignored in every other state.
- DECODE (1 cycle):
  - wr_ctrl_addr_offset = ctrl_addr_offset + zero-extended dram_start.
  - wr_ctrl_xfer_size_in_bytes = zero-extended dram_bytes.
  - Both outputs hold stable until return to IDLE.
  - If buf_len==0 or group is not 6'b000001 / 6'b000010: assert ap_done the next cycle (1 cycle), return to IDLE, no wr_ctrl_start.
  - Otherwise go to START.
- START (1 cycle): wr_ctrl_start=1, then STREAM.
- STREAM, read issue:
  - Read k (k=0..buf_len-1) uses address buf_start[10:0]+k modulo 2^C_BUFFER_ADDR_WIDTH (wraps 2047->0).
  - The strobe is asserted only on the selected buffer (group bit0 -> buffer_0, bit1 -> buffer_1). The other strobe stays 0.
  - Issue a read in a cycle iff reads issued < buf_len and fifo_count + inflight - pop < 2, where pop = data_tvalid & data_tready.
- STREAM, FIFO:
  - Returned data enters the 2-entry FIFO on the cycle after the strobe.
  - data_tvalid = FIFO non-empty; data_tdata = FIFO head.
  - data_tvalid, once high, holds with stable data until accepted.
  - The FIFO never overflows; simultaneous push and pop keep the count.
  - With data_tready held 1, throughput is 1 beat/cycle.
  - First data_tvalid appears 2 cycles after the START cycle (read issued cycle S+1, valid S+2).
- STREAM, completion:
  - data_tlast=1 only on beat buf_len-1.
  - After that beat is accepted, go to WAIT_DONE.
- WAIT_DONE:
  - On wr_ctrl_done=1: ap_done=1 the next cycle for exactly 1 cycle, state IDLE.
  - A wr_ctrl_done pulse that arrives during STREAM is remembered and honoured at entry to WAIT_DONE.
- Back-to-back instructions: ap_start is accepted in the same cycle ap_done is high (state IDLE).

Test Plan:
- group=1, buf_start=16, buf_len=4, dram_start=0x40, offset=0x1000, tready=1:
  - reads at addrs 16..19 on buffer_0 only; wr_ctrl_addr_offset=0x1040.
  - 4 consecutive beats, tlast on the 4th.
  - wr_ctrl_done 3 cycles later -> ap_done the next cycle.
- Same instruction, tready toggling 1,0,0,1,0,1…:
  - beats are emitted in order with no loss or duplication; tdata is stable while tvalid&!tready.
  - never more than 2 reads outstanding plus buffered.
- group=2, buf_start=2046, buf_len=4:
  - buffer_1 addresses 2046,2047,0,1; buffer_0 strobe never asserts.
- buf_len=0, and separately group=6'b000100:
  - no read strobe, no wr_ctrl_start; ap_done pulses 2 cycles after ap_start.
- ap_start re-asserted during STREAM:
  - ignored; after ap_done, a new ap_start is accepted in the same cycle ap_done is high.
- kernel_rst asserted mid-STREAM after 2 beats:
  - next cycle all outputs are 0 except ap_done=1 for that single cycle.
  - a subsequent instruction completes normally from an empty FIFO.
